// File: rtl/microwave_ctrl.sv
// Microwave operating-mode controller: key edge detection, cook/pause/done FSM, 1 s tick
// strobe and timer strobes. Optional done beep is built only when MWC_DONE_BEEP_EN is defined.
module microwave_ctrl #(
    parameter int unsigned TICK_DIV    = 50_000_000,
    parameter int unsigned BEEP_CYCLES = 25_000_000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       startn,
    input  logic       stopn,
    input  logic       clearn,
    input  logic       keyn,
    input  logic       door_closed,
    input  logic       timer_zero,
    output logic       timer_enn,
    output logic       timer_loadn,
    output logic       timer_clrn,
    output logic       mag_on,
    output logic [2:0] state,
    output logic       beep
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SET   = 3'd1,
        S_COOK  = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int unsigned TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);

    state_t        state_q, state_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          mag_on_q, mag_on_d;
    logic          timer_enn_q, timer_enn_d;
    logic          timer_loadn_q, timer_loadn_d;
    logic          timer_clrn_q, timer_clrn_d;
    logic          startn_q, stopn_q, clearn_q, keyn_q;

    logic ev_start, ev_stop, ev_clear, ev_key, can_start;

    // Key samples reset to 1 so a key held through reset never produces an event.
    assign ev_start  = startn_q & ~startn;
    assign ev_stop   = stopn_q  & ~stopn;
    assign ev_clear  = clearn_q & ~clearn;
    assign ev_key    = keyn_q   & ~keyn;
    assign can_start = door_closed & ~timer_zero;

    always_comb begin
        state_d       = state_q;
        tick_cnt_d    = tick_cnt_q;
        timer_enn_d   = 1'b1;
        timer_loadn_d = 1'b1;
        timer_clrn_d  = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (ev_clear) begin
                    timer_clrn_d = 1'b0;
                end else if (!ev_stop && !ev_start && ev_key) begin
                    timer_loadn_d = 1'b0;
                    state_d       = S_SET;
                end
            end
            S_SET: begin
                if (ev_clear) begin
                    timer_clrn_d = 1'b0;
                    state_d      = S_IDLE;
                end else if (!ev_stop && ev_start) begin
                    if (can_start) state_d = S_COOK;
                end else if (!ev_stop && ev_key) begin
                    timer_loadn_d = 1'b0;
                end
            end
            S_COOK: begin
                // Zero wins over a pause request; the interrupted second is kept for resume.
                if (timer_zero) begin
                    state_d = S_DONE;
                end else if (ev_stop || !door_closed) begin
                    state_d = S_PAUSE;
                end else if (tick_cnt_q == TICK_MAX) begin
                    tick_cnt_d  = '0;
                    timer_enn_d = 1'b0;
                end else begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                end
            end
            S_PAUSE: begin
                if (ev_clear) begin
                    timer_clrn_d = 1'b0;
                    tick_cnt_d   = '0;
                    state_d      = S_IDLE;
                end else if (!ev_stop && ev_start && can_start) begin
                    state_d = S_COOK;
                end
            end
            S_DONE: begin
                if (ev_key || ev_start || ev_stop || ev_clear || !door_closed) begin
                    state_d    = S_IDLE;
                    tick_cnt_d = '0;
                end
            end
            default: begin
                state_d    = S_IDLE;
                tick_cnt_d = '0;
            end
        endcase
        mag_on_d = (state_d == S_COOK);
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q       <= S_IDLE;
            tick_cnt_q    <= '0;
            mag_on_q      <= 1'b0;
            timer_enn_q   <= 1'b1;
            timer_loadn_q <= 1'b1;
            timer_clrn_q  <= 1'b1;
            startn_q      <= 1'b1;
            stopn_q       <= 1'b1;
            clearn_q      <= 1'b1;
            keyn_q        <= 1'b1;
        end else begin
            state_q       <= state_d;
            tick_cnt_q    <= tick_cnt_d;
            mag_on_q      <= mag_on_d;
            timer_enn_q   <= timer_enn_d;
            timer_loadn_q <= timer_loadn_d;
            timer_clrn_q  <= timer_clrn_d;
            startn_q      <= startn;
            stopn_q       <= stopn;
            clearn_q      <= clearn;
            keyn_q        <= keyn;
        end
    end

`ifdef MWC_DONE_BEEP_EN
    localparam int unsigned BW = $clog2(BEEP_CYCLES + 1);

    logic [BW-1:0] beep_cnt_q, beep_cnt_d;
    logic          beep_q, beep_d;

    always_comb begin
        beep_d     = 1'b0;
        beep_cnt_d = beep_cnt_q;
        if (state_d == S_DONE) begin
            if (state_q != S_DONE) begin
                beep_d     = 1'b1;
                beep_cnt_d = BW'(BEEP_CYCLES - 1);
            end else if (beep_cnt_q != '0) begin
                beep_d     = 1'b1;
                beep_cnt_d = beep_cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            beep_cnt_q <= '0;
            beep_q     <= 1'b0;
        end else begin
            beep_cnt_q <= beep_cnt_d;
            beep_q     <= beep_d;
        end
    end

    assign beep = beep_q;
`else
    assign beep = 1'b0;
`endif

    assign state       = state_q;
    assign mag_on      = mag_on_q;
    assign timer_enn   = timer_enn_q;
    assign timer_loadn = timer_loadn_q;
    assign timer_clrn  = timer_clrn_q;

endmodule
